// File: rtl/rr_grant_sched4.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_sched4
// Purpose  : Four-client round-robin scheduler that drives an encoded owner
//            index plus enable for a shared 2-to-4 decode path, with hold
//            timeout and one mandatory idle cycle between owners.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_sched4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] gnt_idx,
    output logic       gnt_en,
    output logic [3:0] gnt,
    output logic       busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_en_q, gnt_en_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] w_win;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        w_win = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr_q + 2'(i)]) begin
                w_win = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_en_d   = gnt_en_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    gnt_idx_d  = w_win;
                    gnt_en_d   = 1'b1;
                    hold_cnt_d = 8'd0;
                    ptr_d      = w_win + 2'd1;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_q] || (hold_cnt_q == c_HOLD_LAST)) begin
                    state_d    = IDLE;
                    gnt_en_d   = 1'b0;
                    hold_cnt_d = 8'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            gnt_idx_q  <= 2'd0;
            gnt_en_q   <= 1'b0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_en_q   <= gnt_en_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // One-hot grant is a pure decode of the registered index and enable.
    for (genvar k = 0; k < 4; k++) begin : g_gnt
        assign gnt[k] = gnt_en_q & (gnt_idx_q == 2'(k));
    end

    assign gnt_idx = gnt_idx_q;
    assign gnt_en  = gnt_en_q;
    assign busy    = (state_q == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_sched4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_sched4
// Purpose  : Bench for rr_grant_sched4: three instances (MAX_HOLD 8/4/1) on a
//            shared request bus, checked against a round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_sched4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] d_idx  [3];
    logic       d_en   [3];
    logic [3:0] d_gnt  [3];
    logic       d_busy [3];

    int checks = 0;
    int errors = 0;

    rr_grant_sched4 #(.MAX_HOLD(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt_idx(d_idx[0]), .gnt_en(d_en[0]), .gnt(d_gnt[0]), .busy(d_busy[0]));
    rr_grant_sched4 #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt_idx(d_idx[1]), .gnt_en(d_en[1]), .gnt(d_gnt[1]), .busy(d_busy[1]));
    rr_grant_sched4 #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt_idx(d_idx[2]), .gnt_en(d_en[2]), .gnt(d_gnt[2]), .busy(d_busy[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: owner, whether granted, cycles granted so far, and priority start.
    int m_own  [3];
    int m_used [3];
    int m_ptr  [3];
    bit m_en   [3];
    int c_maxh [3] = '{8, 4, 1};

    always @(posedge clk or negedge rst_n) begin
        for (int n = 0; n < 3; n++) begin
            if (!rst_n) begin
                m_own[n] = 0; m_used[n] = 0; m_ptr[n] = 0; m_en[n] = 1'b0;
            end else if (!m_en[n]) begin
                if (req != 4'b0000) begin
                    for (int off = 3; off >= 0; off--) begin
                        if (req[(m_ptr[n] + off) % 4]) m_own[n] = (m_ptr[n] + off) % 4;
                    end
                    m_en[n]   = 1'b1;
                    m_used[n] = 1;
                    m_ptr[n]  = (m_own[n] + 1) % 4;
                end
            end else if (!req[m_own[n]] || m_used[n] == c_maxh[n]) begin
                m_en[n] = 1'b0;
            end else begin
                m_used[n]++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) begin
            check($sformatf("model_gnt[%0d]", n), int'(d_gnt[n]),
                  m_en[n] ? (1 << m_own[n]) : 0);
            check($sformatf("model_en[%0d]", n), int'(d_en[n]), int'(m_en[n]));
            check($sformatf("model_idx[%0d]", n), int'(d_idx[n]), m_own[n]);
            check($sformatf("model_busy[%0d]", n), int'(d_busy[n]), int'(m_en[n]));
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp8 [18];
    logic [3:0] exp1 [8];
    logic [3:0] exp4 [10];

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check("reset_gnt", int'(d_gnt[0]), 0);
        check("reset_en", int'(d_en[0]), 0);

        // Full load: MAX_HOLD=8 and MAX_HOLD=1 literal sequences.
        do_reset();
        for (int c = 0; c < 18; c++) exp8[c] = 4'b0000;
        for (int c = 0; c < 8; c++) exp8[c] = 4'b0001;
        for (int c = 9; c < 17; c++) exp8[c] = 4'b0010;
        exp1 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        req = 4'b1111;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            check($sformatf("full8_c%0d", c), int'(d_gnt[0]), int'(exp8[c]));
            if (c < 8) check($sformatf("full1_c%0d", c), int'(d_gnt[2]), int'(exp1[c]));
        end

        // Reset mid-grant, then first grant goes to client 0.
        do_reset();
        req = 4'b0100;
        repeat (2) @(negedge clk);
        check("pre_rst_gnt", int'(d_gnt[0]), 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_gnt", int'(d_gnt[0]), 0);
        check("midrst_en", int'(d_en[0]), 0);
        check("midrst_idx", int'(d_idx[0]), 0);
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_gnt", int'(d_gnt[0]), 4'b0001);

        // Single client, then wrap-around from ptr=3.
        do_reset();
        req = 4'b0100;
        repeat (3) begin
            @(negedge clk);
            check("single_gnt", int'(d_gnt[0]), 4'b0100);
        end
        req = 4'b0000;
        @(negedge clk);
        check("single_drop", int'(d_gnt[0]), 0);
        req = 4'b1001;
        @(negedge clk);
        check("wrap_first3", int'(d_gnt[0]), 4'b1000);
        req = 4'b0001;
        @(negedge clk);
        check("wrap_idle", int'(d_gnt[0]), 0);
        check("wrap_idx_hold", int'(d_idx[0]), 3);
        @(negedge clk);
        check("wrap_then0", int'(d_gnt[0]), 4'b0001);

        // Timeout re-grant with MAX_HOLD=4.
        do_reset();
        exp4 = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("tmo4_c%0d", c), int'(d_gnt[1]), int'(exp4[c]));
        end

        // Owner drops while another client raises at the same edge.
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        check("simul_own0", int'(d_gnt[0]), 4'b0001);
        req = 4'b0010;
        @(negedge clk);
        check("simul_idle", int'(d_gnt[0]), 0);
        @(negedge clk);
        check("simul_new1", int'(d_gnt[0]), 4'b0010);

        // Randomized traffic with sticky requests and occasional async reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_grant_sched4.md
# rr_grant_sched4

Four-requester round-robin scheduler that shares one 2-to-4 enable-gated decode path (e.g. a one-hot select or bus-enable bank) between four clients. It picks one requester at a time and holds the grant until release or timeout. It drives the encoded owner index plus an enable, and the one-hot grant equals the decode of that index gated by the enable. It sits between client request lines and the shared resource's select/enable inputs.

## Interface
- MAX_HOLD, default 8: maximum consecutive grant cycles per owner; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per client; req[k] high = client k wants the resource.
- gnt_idx  out  2  encoded current/last owner; gnt_idx[1] is MSB.
- gnt_en  out  1  grant active; the decode enable.
- gnt  out  4  one-hot grant; gnt[k] = gnt_en & (gnt_idx == k); 4'b0000 when gnt_en=0.
- busy  out  1  high in GRANT state (equals gnt_en).

## Operation
- Registered state: state {IDLE, GRANT}, ptr[1:0] (highest-priority index), hold_cnt[7:0], gnt_idx, gnt_en.
- Reset (async, rst_n=0): state=IDLE, ptr=0, hold_cnt=0, gnt_idx=0, gnt_en=0, so gnt=0 and busy=0. Takes effect immediately, including mid-grant.
- IDLE:
  - If req==0, stay. gnt_idx holds its last value; gnt_en=0.
  - Else pick the winner w = the first k with req[k]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the edge: gnt_idx=w, gnt_en=1, hold_cnt=0, ptr=(w+1) mod 4 (3 wraps to 0), state=GRANT.
- GRANT, each edge:
  - If req[gnt_idx]==0 or hold_cnt==MAX_HOLD-1: state=IDLE, gnt_en=0, hold_cnt=0.
  - Otherwise hold_cnt=hold_cnt+1.
  - Requests from non-owners never pre-empt the owner.
- Release always passes through at least one IDLE cycle: a mandatory turnaround with gnt=0 between owners. Back-to-back grants to different clients are separated by exactly one idle cycle.
- A timed-out owner that keeps requesting re-enters arbitration at its rotated priority. Because ptr has already advanced past it, it wins again only if no other client requests.
- hold_cnt never exceeds MAX_HOLD-1 and does not wrap.
- gnt is purely combinational from gnt_idx and gnt_en (no extra logic on req), so it is glitch-free relative to clk.

## Timing
- Request-to-grant latency: req sampled high at edge N in IDLE gives gnt high from edge N to N+1 onward (one cycle).
- Grant duration: min 1 cycle, max MAX_HOLD cycles.
- Owner release: if req[owner] is low at edge M, gnt drops after edge M. The owner may see one cycle of gnt after lowering req.
- Turnaround: at least 1 IDLE cycle between grants. Full-load period per grant is MAX_HOLD+1 cycles.
- Simultaneous owner release and new requests: release wins at that edge; the new winner is chosen at the next edge (IDLE).
- Request raised and dropped within IDLE before an edge samples it is ignored.
- Reset deassertion: first arbitration happens at the first rising edge with rst_n=1; ptr=0, so client 0 has top priority.

## Test plan
- Reset mid-grant: owner 2 granted, pull rst_n low between edges -> gnt=0000, gnt_en=0, gnt_idx=00 immediately. After release with req=1111 -> first grant is gnt=0001.
- Single client: req=0100 for 3 cycles, then 0000 -> gnt=0100 starting 1 cycle after req rises. gnt drops on the first edge sampling req[2]=0; ptr becomes 3.
- Full load, MAX_HOLD=8, req=1111 held -> gnt sequence 0001,0010,0100,1000,0001. Each grant lasts 8 cycles with exactly 1 cycle of 0000 between grants.
- Wrap-around: after a grant to client 2 (ptr=3), req=1001 -> client 3 granted first, then client 0. With req=0001 only -> client 0 still wins (scan wraps).
- Timeout re-grant: MAX_HOLD=4, req=0010 held -> gnt=0010 for 4 cycles, 0000 for 1 cycle, 0010 again. Repeats with period 5.
- Simultaneous release and new request: owner 0 drops req at the same edge client 1 raises req -> 1 idle cycle, then gnt=0010. MAX_HOLD=1 with req=1111 -> 1-cycle grants alternating with 1 idle cycle, in order 0,1,2,3.
